// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order FIFO of {op1,op2,oprn,dst} (in_*) feeding an external combinational ALU (alu_*), with one registered result slot (res_*), occupancy count_o, sync flush_i and async rst_i.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int DST_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_op1_i,
  input  logic [31:0]              in_op2_i,
  input  logic [5:0]               in_oprn_i,
  input  logic [DST_W-1:0]         in_dst_i,
  output logic [31:0]              alu_op1_o,
  output logic [31:0]              alu_op2_o,
  output logic [5:0]               alu_oprn_o,
  input  logic [31:0]              alu_out_i,
  input  logic                     alu_zero_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_data_o,
  output logic                     res_zero_o,
  output logic [DST_W-1:0]         res_dst_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]      op1_q  [DEPTH];
  logic [31:0]      op2_q  [DEPTH];
  logic [5:0]       oprn_q [DEPTH];
  logic [DST_W-1:0] dst_q  [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             res_valid_q, res_valid_d, res_zero_q, res_zero_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [DST_W-1:0] res_dst_q, res_dst_d;
  logic             busy, enq, fire, deq;
  always_comb begin
    busy        = count_q != '0;
    in_ready_o  = count_q < FULL;
    enq         = in_valid_i && in_ready_o && !flush_i;
    fire        = busy && (!res_valid_q || res_ready_i);
    deq         = fire && !flush_i;
    alu_op1_o   = busy ? op1_q[rptr_q] : '0;
    alu_op2_o   = busy ? op2_q[rptr_q] : '0;
    alu_oprn_o  = busy ? oprn_q[rptr_q] : '0;
    wptr_d      = flush_i ? '0 : wptr_q + AW'(enq);
    rptr_d      = flush_i ? '0 : rptr_q + AW'(deq);
    count_d     = flush_i ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
    res_valid_d = flush_i ? 1'b0 : fire ? 1'b1 : res_ready_i ? 1'b0 : res_valid_q;
    res_data_d  = deq ? alu_out_i : res_data_q;
    res_zero_d  = deq ? alu_zero_i : res_zero_q;
    res_dst_d   = deq ? dst_q[rptr_q] : res_dst_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_dst_q   <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_dst_q   <= res_dst_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      op1_q[wptr_q]  <= in_op1_i;
      op2_q[wptr_q]  <= in_op2_i;
      oprn_q[wptr_q] <= in_oprn_i;
      dst_q[wptr_q]  <= in_dst_i;
    end
  end
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_zero_o  = res_zero_q;
  assign res_dst_o   = res_dst_q;
  assign count_o     = count_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed stimulus with a result scoreboard checked by an independent monitor
module tb_alu_issue_queue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, alu_zero, res_valid, res_ready, res_zero;
  logic [31:0] in_op1, in_op2, alu_op1, alu_op2, alu_out, res_data;
  logic [5:0]  in_oprn, alu_oprn;
  logic [4:0]  in_dst, res_dst;
  logic [2:0]  count;
  logic        rr = 1'b1;
  logic [37:0] exp_q [$];
  logic [37:0] e;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  alu_issue_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op1_i(in_op1), .in_op2_i(in_op2), .in_oprn_i(in_oprn), .in_dst_i(in_dst),
    .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_oprn_o(alu_oprn),
    .alu_out_i(alu_out), .alu_zero_i(alu_zero),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_zero_o(res_zero), .res_dst_o(res_dst),
    .count_o(count)
  );
  always_comb begin
    case (alu_oprn)
      6'h01:   alu_out = alu_op1 + alu_op2;
      6'h02:   alu_out = alu_op1 - alu_op2;
      6'h09:   alu_out = {31'b0, alu_op1 < alu_op2};
      default: alu_out = 32'hA5A5_0000 | {26'b0, alu_oprn};
    endcase
    alu_zero = alu_out == 32'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                       input logic [4:0] d, input logic [31:0] ed, input logic ez, input logic acc);
    @(negedge clk);
    res_ready = rr;
    in_valid = 1'b1;
    in_op1 = a;
    in_op2 = b;
    in_oprn = op;
    in_dst = d;
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, acc});
    if (acc) exp_q.push_back({ez, d, ed});
  endtask
  task automatic idle();
    @(negedge clk);
    res_ready = rr;
    in_valid = 1'b0;
    #1;
  endtask
  always @(negedge clk) begin
    #1;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stale_result: got data %0h dst %0h expected no result", res_data, res_dst);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_dst", {27'b0, res_dst}, {27'b0, e[36:32]});
        chk("res_zero", {31'b0, res_zero}, {31'b0, e[37]});
      end
    end
  end
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    in_op1 = '0; in_op2 = '0; in_oprn = '0; in_dst = '0;
    #3;
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_alu_op1", alu_op1, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'b0, in_ready}, 1);
    // add with latency and single-cycle pulse
    issue(5, 7, 6'h01, 3, 12, 0, 1);
    idle();
    chk("lat_edge1_valid", {31'b0, res_valid}, 0);
    chk("head_alu_op1", alu_op1, 5);
    chk("head_alu_oprn", {26'b0, alu_oprn}, 1);
    idle();
    chk("lat_edge2_valid", {31'b0, res_valid}, 1);
    idle();
    chk("lat_pulse_end", {31'b0, res_valid}, 0);
    // zero flag, slt, undefined opcodes back-to-back
    issue(9, 9, 6'h02, 1, 0, 1, 1);
    issue(3, 5, 6'h09, 2, 1, 0, 1);
    issue(1, 2, 6'h0A, 4, 32'hA5A5_000A, 0, 1);
    issue(6, 7, 6'h00, 5, 32'hA5A5_0000, 0, 1);
    repeat (4) idle();
    // backpressure: 5 accepted, 6th refused
    rr = 1'b0;
    idle();
    issue(1, 1, 6'h01, 1, 2, 0, 1);
    issue(2, 2, 6'h01, 2, 4, 0, 1);
    issue(3, 3, 6'h01, 3, 6, 0, 1);
    issue(4, 4, 6'h01, 4, 8, 0, 1);
    issue(5, 5, 6'h01, 5, 10, 0, 1);
    issue(6, 6, 6'h01, 6, 12, 0, 0);
    idle();
    chk("bp_count", {29'b0, count}, 4);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_res_valid", {31'b0, res_valid}, 1);
    chk("bp_hold_data", res_data, 2);
    idle();
    chk("bp_hold_data2", res_data, 2);
    rr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("bp_stream_valid", {31'b0, res_valid}, 1);
    end
    idle();
    chk("bp_drained_valid", {31'b0, res_valid}, 0);
    chk("bp_drained_count", {29'b0, count}, 0);
    // steady state at COUNT=2 with pointer wrap
    rr = 1'b0;
    issue(10, 1, 6'h01, 1, 11, 0, 1);
    issue(20, 2, 6'h01, 2, 22, 0, 1);
    issue(30, 3, 6'h01, 3, 33, 0, 1);
    rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(32'(i), 100, 6'h01, 5'(8 + i), 32'(i + 100), 0, 1);
      chk("steady_count", {29'b0, count}, 2);
    end
    repeat (4) idle();
    chk("steady_drain_count", {29'b0, count}, 0);
    // asynchronous reset with 3 queued and 1 held
    rr = 1'b0;
    issue(7, 8, 6'h01, 9, 15, 0, 1);
    issue(1, 0, 6'h01, 10, 1, 0, 1);
    issue(2, 0, 6'h01, 11, 2, 0, 1);
    issue(3, 0, 6'h01, 12, 3, 0, 1);
    idle();
    chk("pre_rst_count", {29'b0, count}, 3);
    chk("pre_rst_res_data", res_data, 15);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {29'b0, count}, 0);
    chk("arst_res_valid", {31'b0, res_valid}, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_res_dst", {27'b0, res_dst}, 0);
    chk("arst_alu_op1", alu_op1, 0);
    chk("arst_alu_oprn", {26'b0, alu_oprn}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    exp_q.delete();
    #1 rst = 1'b0;
    rr = 1'b1;
    repeat (3) idle();
    chk("post_arst_valid", {31'b0, res_valid}, 0);
    // flush with simultaneous issue
    rr = 1'b0;
    issue(7, 8, 6'h01, 9, 15, 0, 1);
    issue(1, 0, 6'h01, 10, 1, 0, 1);
    issue(2, 0, 6'h01, 11, 2, 0, 1);
    issue(3, 0, 6'h01, 12, 3, 0, 1);
    idle();
    chk("pre_flush_count", {29'b0, count}, 3);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    in_op1 = 99; in_op2 = 1; in_oprn = 6'h01; in_dst = 7;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_count", {29'b0, count}, 0);
    chk("flush_res_valid", {31'b0, res_valid}, 0);
    chk("flush_alu_op1", alu_op1, 0);
    rr = 1'b1;
    repeat (2) idle();
    chk("flush_no_accept", {29'b0, count}, 0);
    issue(40, 2, 6'h01, 9, 42, 0, 1);
    repeat (3) idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 SHALL have parameter DST_W, default 5: destination-tag width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port FLUSH  input  1  synchronous discard of all queued and held work.
REQ-006 SHALL have ports IN_VALID input 1, IN_READY output 1: issue handshake.
REQ-007 SHALL have ports IN_OP1 input 32, IN_OP2 input 32, IN_OPRN input 6, IN_DST input DST_W: issued operation.
REQ-008 SHALL have ports ALU_OP1 output 32, ALU_OP2 output 32, ALU_OPRN output 6: drive the combinational ALU operands and opcode.
REQ-009 SHALL have ports ALU_OUT input 32, ALU_ZERO input 1: ALU result and zero flag, same cycle.
REQ-010 SHALL have ports RES_VALID output 1, RES_READY input 1: result handshake.
REQ-011 SHALL have ports RES_DATA output 32, RES_ZERO output 1, RES_DST output DST_W: registered result.
REQ-012 SHALL have port COUNT output log2(DEPTH)+1: occupied queue entries.

Function
REQ-013 SHALL be a FIFO of {OP1, OP2, OPRN, DST} entries, DEPTH deep, with read/write pointers wrapping modulo DEPTH.
REQ-014 SHALL drive IN_READY = (COUNT < DEPTH) combinationally, with no same-cycle pass-through when full.
REQ-015 SHALL enqueue on a rising edge when IN_VALID and IN_READY are both high and FLUSH is low.
REQ-016 SHALL ignore IN_VALID while IN_READY is low, leaving the queue unchanged.
REQ-017 SHALL drive ALU_OP1/ALU_OP2/ALU_OPRN from the head entry when COUNT > 0, and all-zero otherwise.
REQ-018 SHALL define fire = (COUNT > 0) and (RES_VALID low or RES_READY high).
REQ-019 SHALL, on fire, dequeue the head and load RES_DATA <= ALU_OUT, RES_ZERO <= ALU_ZERO, RES_DST <= head DST, and RES_VALID <= 1.
REQ-020 SHALL, when RES_VALID and RES_READY are high without fire, clear RES_VALID and hold RES_DATA/RES_ZERO/RES_DST.
REQ-021 SHALL hold RES_DATA/RES_ZERO/RES_DST stable while RES_VALID is high and RES_READY is low.
REQ-022 SHALL, on simultaneous enqueue and fire, leave COUNT unchanged and advance both pointers.
REQ-023 SHALL give a latency of two rising edges from the accept edge to RES_VALID high when the queue is empty and RES_READY is high.
REQ-024 SHALL sustain a throughput of one result per cycle.
REQ-025 SHALL preserve issue order in the results.
REQ-026 SHALL pass undefined opcodes (0x0, 0xA-0x3F) through unmodified, returning whatever the ALU produces.
REQ-027 SHALL, on FLUSH high at a rising edge, set COUNT to 0, reset both pointers, and clear RES_VALID.
REQ-028 SHALL give FLUSH priority over enqueue and fire in the same cycle.

Reset
REQ-029 SHALL, while RST is high, immediately force COUNT=0, pointers=0, RES_VALID=0, RES_DATA=0, RES_ZERO=0, RES_DST=0, and ALU_OP1/ALU_OP2/ALU_OPRN=0, independent of CLK.
REQ-030 SHALL, when RST is asserted mid-operation, discard all queued entries and any held result without emitting it.
REQ-031 SHALL drive IN_READY=1 during and immediately after reset.

Verification
REQ-032 SHALL be verified for add: issue OP1=5, OP2=7, OPRN=0x01, DST=3 with RES_READY=1 -> RES_DATA=12, RES_ZERO=0, RES_DST=3, RES_VALID high exactly two edges after accept, for one cycle.
REQ-033 SHALL be verified for zero flag: issue OP1=9, OP2=9, OPRN=0x02 -> RES_DATA=0, RES_ZERO=1; then OP1=3, OP2=5, OPRN=0x09 -> RES_DATA=1.
REQ-034 SHALL be verified for backpressure: hold RES_READY=0 and issue 6 ops back-to-back -> 5 accepted (4 queued plus 1 held), COUNT=4, IN_READY=0, RES_DATA held constant; release RES_READY -> all 5 results emerge in issue order, one per cycle.
REQ-035 SHALL be verified for steady state: with COUNT=2 and RES_READY=1, enqueue every cycle -> COUNT stays 2 and pointers wrap past DEPTH-1 correctly.
REQ-036 SHALL be verified for reset and flush: pulse RST asynchronously between edges with 3 entries queued -> outputs zero before the next edge and no stale result appears; repeat using FLUSH plus a simultaneous IN_VALID -> COUNT=0, RES_VALID=0, new op not accepted.
